// File: rtl/pll_rst_pkg.sv
// rtl/pll_rst_pkg.sv - shared state type, default constants and counter-width helper for the PLL lock reset controller
package pll_rst_pkg;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_STABLE = 2'd1,
        S_RUN    = 2'd2,
        S_LOST   = 2'd3
    } state_e;

    localparam int DEF_STABLE_COUNTS  = 1000;
    localparam int DEF_HOLD_COUNTS    = 16;
    localparam int DEF_LOSS_CNT_W     = 8;
    localparam int DEF_TIMEOUT_COUNTS = 1_000_000;

    // Width needed to hold the larger of two terminal counts; never below one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// rtl/bit_sync_2ff.sv - two-flop single-bit synchroniser with synchronous active-low clear
module bit_sync_2ff (
    input  logic clk_i,
    input  logic clr_n_i,
    input  logic d_i,
    output logic q_o
);

    logic sync1_q;
    logic sync2_q;

    // Two-stage capture of the asynchronous input; clear forces both stages low.
    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule

// File: rtl/pll_lock_reset_ctrl.sv
// rtl/pll_lock_reset_ctrl.sv - PLL lock qualifier and downstream reset generator; LOCK_TIMEOUT_EN adds a lock-acquire timeout flag
module pll_lock_reset_ctrl
    import pll_rst_pkg::*;
#(
    parameter int STABLE_COUNTS  = DEF_STABLE_COUNTS,
    parameter int HOLD_COUNTS    = DEF_HOLD_COUNTS,
`ifdef LOCK_TIMEOUT_EN
    parameter int TIMEOUT_COUNTS = DEF_TIMEOUT_COUNTS,
`endif
    parameter int LOSS_CNT_W     = DEF_LOSS_CNT_W
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  locked_in,
    input  logic                  force_rst,
    output logic                  rst_out,
    output logic                  ready,
`ifdef LOCK_TIMEOUT_EN
    output logic                  lock_timeout,
`endif
    output logic [LOSS_CNT_W-1:0] loss_count
);

    localparam int CNT_W = cnt_width(STABLE_COUNTS, HOLD_COUNTS);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_COUNTS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_COUNTS - 1);

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [LOSS_CNT_W-1:0] loss_q;
    logic [LOSS_CNT_W-1:0] loss_d;
    logic                  rst_q;
    logic                  ready_q;
    logic                  locked_s;
    logic                  run_enter;

    bit_sync_2ff u_lock_sync (
        .clk_i   (clk),
        .clr_n_i (n_rst),
        .d_i     (locked_in),
        .q_o     (locked_s)
    );

    // Lock has been stable for the full qualification window on this edge.
    assign run_enter = (state_q == S_STABLE) && locked_s && (cnt_q == STABLE_LAST);

    // Saturating increment of the lock-loss counter.
    always_comb begin
        loss_d = loss_q;
        if (loss_q != {LOSS_CNT_W{1'b1}}) begin
            loss_d = loss_q + 1'b1;
        end
    end

    // Reset sequencing FSM; rst_out/ready are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
            loss_q  <= '0;
            rst_q   <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (locked_s) begin
                        state_q <= S_STABLE;
                        cnt_q   <= '0;
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_q <= S_WAIT;
                        cnt_q   <= '0;
                    end else if (run_enter) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                        rst_q   <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    // Lock loss takes priority so a coincident force_rst still counts once.
                    if (!locked_s || force_rst) begin
                        state_q <= S_LOST;
                        cnt_q   <= '0;
                        rst_q   <= 1'b1;
                        ready_q <= 1'b0;
                        if (!locked_s) begin
                            loss_q <= loss_d;
                        end
                    end
                end
                S_LOST: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q <= S_WAIT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_WAIT;
                    cnt_q   <= '0;
                    rst_q   <= 1'b1;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign rst_out    = rst_q;
    assign ready      = ready_q;
    assign loss_count = loss_q;

`ifdef LOCK_TIMEOUT_EN
    localparam int TO_W = cnt_width(TIMEOUT_COUNTS, 1);
    localparam logic [TO_W-1:0] TO_FULL = TO_W'(TIMEOUT_COUNTS);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_COUNTS - 1);

    logic [TO_W-1:0] tcnt_q;
    logic            timeout_q;

    // Diagnostic count of cycles spent outside S_RUN; flag is sticky until the next run entry.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else if (run_enter) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else if (state_q != S_RUN) begin
            if (tcnt_q != TO_FULL) begin
                tcnt_q <= tcnt_q + 1'b1;
            end
            if (tcnt_q == TO_LAST) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign lock_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// tb/tb_pll_lock_reset_ctrl.sv - directed table-driven bench for pll_lock_reset_ctrl
module tb_pll_lock_reset_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       locked_in;
    logic       force_rst;
    logic       rst_out;
    logic       ready;
    logic [1:0] loss_count;
`ifdef LOCK_TIMEOUT_EN
    logic       lock_timeout;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       n_rst;
        logic       locked;
        logic       frc;
        logic       exp_rst;
        logic       exp_ready;
        logic [1:0] exp_loss;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pll_lock_reset_ctrl #(
        .STABLE_COUNTS  (8),
        .HOLD_COUNTS    (4),
`ifdef LOCK_TIMEOUT_EN
        .TIMEOUT_COUNTS (50),
`endif
        .LOSS_CNT_W     (2)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .locked_in    (locked_in),
        .force_rst    (force_rst),
        .rst_out      (rst_out),
        .ready        (ready),
`ifdef LOCK_TIMEOUT_EN
        .lock_timeout (lock_timeout),
`endif
        .loss_count   (loss_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input int n, input logic nr, input logic lk, input logic fr,
                       input logic er, input logic ey, input logic [1:0] el);
        vec_t v;
        v.n_rst = nr; v.locked = lk; v.frc = fr;
        v.exp_rst = er; v.exp_ready = ey; v.exp_loss = el;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic er, input logic ey, input int el);
        chk({tag, ".rst_out"}, int'(rst_out), int'(er));
        chk({tag, ".ready"}, int'(ready), int'(ey));
        chk({tag, ".loss_count"}, int'(loss_count), el);
    endtask

    // One lock-loss event from S_RUN followed by the deterministic recovery back to S_RUN.
    task automatic loss_event(input int exp_loss);
        locked_in = 1'b0;
        step(); chk_out("loss_k0", 1'b0, 1'b1, -1 == 0 ? 0 : int'(loss_count));
        step(); chk_out("loss_k1", 1'b0, 1'b1, int'(loss_count));
        step(); chk_out("loss_k2", 1'b1, 1'b0, exp_loss);
        locked_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(); chk_out("loss_hold", 1'b1, 1'b0, exp_loss);
        end
        step(); chk_out("loss_rerun", 1'b0, 1'b1, exp_loss);
    endtask

    initial begin
        n_rst = 1'b0; locked_in = 1'b1; force_rst = 1'b0;

        // Power-up, lock qualification, lock loss, glitch in S_STABLE, coincident and lone force_rst.
        add(3,  0, 1, 0, 1, 0, 0);
        add(10, 1, 1, 0, 1, 0, 0);
        add(2,  1, 1, 0, 0, 1, 0);
        add(1,  1, 0, 0, 0, 1, 0);
        add(1,  1, 1, 0, 0, 1, 0);
        add(9,  1, 1, 0, 1, 0, 1);
        add(1,  1, 0, 0, 1, 0, 1);
        add(10, 1, 1, 0, 1, 0, 1);
        add(1,  1, 1, 0, 0, 1, 1);
        add(2,  1, 0, 0, 0, 1, 1);
        add(1,  1, 0, 1, 1, 0, 2);
        add(12, 1, 1, 0, 1, 0, 2);
        add(1,  1, 1, 0, 0, 1, 2);
        add(1,  1, 1, 1, 1, 0, 2);
        add(12, 1, 1, 0, 1, 0, 2);
        add(1,  1, 1, 0, 0, 1, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            n_rst     = vecs[i].n_rst;
            locked_in = vecs[i].locked;
            force_rst = vecs[i].frc;
            step();
            chk($sformatf("vec%0d.rst_out", i), int'(rst_out), int'(vecs[i].exp_rst));
            chk($sformatf("vec%0d.ready", i), int'(ready), int'(vecs[i].exp_ready));
            chk($sformatf("vec%0d.loss_count", i), int'(loss_count), int'(vecs[i].exp_loss));
        end

        // Saturation: three more losses on top of two already counted.
        loss_event(3);
        loss_event(3);
        loss_event(3);

        // n_rst pulse while in S_LOST.
        locked_in = 1'b0;
        step(); step(); step();
        chk_out("mid_lost", 1'b1, 1'b0, 3);
        locked_in = 1'b1;
        step();
        n_rst = 1'b0;
        step(); chk_out("rst_in_lost", 1'b1, 1'b0, 0);
        n_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(); chk_out("reacq", 1'b1, 1'b0, 0);
        end
        step(); chk_out("reacq_run", 1'b0, 1'b1, 0);

`ifdef LOCK_TIMEOUT_EN
        n_rst = 1'b0; locked_in = 1'b0;
        step(); step();
        chk("to_reset", int'(lock_timeout), 0);
        n_rst = 1'b1;
        for (int i = 0; i < 49; i++) step();
        chk("to_before", int'(lock_timeout), 0);
        step(); chk("to_set", int'(lock_timeout), 1);
        for (int i = 0; i < 5; i++) step();
        chk("to_sticky", int'(lock_timeout), 1);
        locked_in = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("to_pre_run", int'(lock_timeout), 1);
        chk("to_pre_run_ready", int'(ready), 0);
        step();
        chk("to_clear", int'(lock_timeout), 0);
        chk("to_clear_ready", int'(ready), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_reset_ctrl.md
Name: pll_lock_reset_ctrl

Overview:
- Sits between the 100 MHz PLL and the Heart_Bit counter domain.
- Synchronises the PLL `locked` flag into the PLL output clock and requires lock to be continuously stable before releasing reset.
- Drives the active-high `rst_out` consumed by downstream logic such as Heart_Bit.
- On lock loss or a software reset request, re-asserts reset for a guaranteed minimum hold time and counts lock-loss events.

Parameters:
- STABLE_COUNTS, 1000, consecutive synchronised-lock cycles required before reset release (10 us at 100 MHz); legal range >=1.
- HOLD_COUNTS, 16, cycles `rst_out` stays asserted in S_LOST before re-arming; legal range >=1.
- LOSS_CNT_W, 8, width of the saturating lock-loss counter.
- TIMEOUT_COUNTS, 1_000_000, lock-acquire timeout in cycles; used only with LOCK_TIMEOUT_EN.

Ports:
- clk, input, 1, PLL output clock (100 MHz); sole clock.
- n_rst, input, 1, synchronous active-low reset.
- locked_in, input, 1, raw PLL locked flag; asynchronous to clk.
- force_rst, input, 1, synchronous software reset request; level-sensitive, honoured only in S_RUN.
- rst_out, output, 1, active-high reset to downstream logic; registered.
- ready, output, 1, high exactly while in S_RUN; registered.
- loss_count, output, LOSS_CNT_W, lock-loss events since n_rst; saturating.
- lock_timeout, output, 1, present only with LOCK_TIMEOUT_EN.

Behaviour:
- Reset: reset is synchronous, active-low; one clock `clk`. n_rst low at a rising edge gives:
  - state=S_WAIT;
  - both sync flops 0, all counters 0;
  - rst_out=1, ready=0, loss_count=0, lock_timeout=0.
  - This holds mid-operation in any state.
- Synchroniser: locked_in feeds two flops (sync1 then sync2). locked_s is sync2.
- Outputs are registered and updated on the same edge as the state register:
  - rst_out=1 in every state except S_RUN;
  - ready = (state==S_RUN).
- S_WAIT:
  - rst_out=1.
  - If locked_s=1, go to S_STABLE and set cnt=0.
- S_STABLE:
  - Each edge with locked_s=1: if cnt==STABLE_COUNTS-1, go to S_RUN; otherwise cnt++.
  - locked_s=0: go to S_WAIT with cnt=0. This is not a loss event, so loss_count is unchanged.
- S_RUN:
  - rst_out=0, ready=1.
  - If locked_s=0, go to S_LOST, cnt=0, loss_count++ (saturates at all-ones).
  - Else if force_rst=1, go to S_LOST, cnt=0, loss_count unchanged.
  - If both occur together, lock loss wins and the count increments once.
- S_LOST:
  - rst_out=1 for exactly HOLD_COUNTS cycles, regardless of locked_s or force_rst.
  - When cnt==HOLD_COUNTS-1, go to S_WAIT; otherwise cnt++.
- Latency: with locked_in held high and sampled at edge 0:
  - locked_s=1 after edge 1;
  - S_STABLE after edge 2;
  - rst_out falls after edge 2+STABLE_COUNTS.
- Lock-loss latency: locked_in low at edge k gives rst_out=1 after edge k+2.
- Counter `cnt` is a single shared counter, width $clog2(max(STABLE_COUNTS,HOLD_COUNTS)+1). It never wraps; it is always cleared on state entry.
- force_rst asserted outside S_RUN is ignored. If held continuously, the block cycles S_RUN→S_LOST→S_WAIT→S_STABLE→S_RUN repeatedly.

Optional Feature:
- LOCK_TIMEOUT_EN defined:
  - Adds a timeout counter that counts cycles while state is not S_RUN, cleared on S_RUN entry and on n_rst.
  - On reaching TIMEOUT_COUNTS, lock_timeout is set to 1. It is sticky until the next S_RUN entry or n_rst; the counter saturates.
  - lock_timeout is diagnostic only and never alters the FSM.
- LOCK_TIMEOUT_EN undefined: lock_timeout port and timeout counter are absent; TIMEOUT_COUNTS is unused.

Decomposition:
- Package pll_rst_pkg holds:
  - state typedef (S_WAIT, S_STABLE, S_RUN, S_LOST; 2-bit binary encoding);
  - constant default values;
  - a counter-width helper function.
- One sub-module, bit_sync_2ff: two-flop synchroniser with synchronous active-low clear, reusable elsewhere.

Test Plan:
1. STABLE_COUNTS=8; n_rst low 3 cycles then high; locked_in=1 from start -> rst_out=1 through edge 9, rst_out=0 and ready=1 after edge 10, loss_count=0.
2. Lock glitch in S_STABLE: locked_in drops for 1 cycle after 5 stable cycles -> return to S_WAIT, full 8-cycle count restarts, loss_count stays 0.
3. Lock loss in S_RUN with HOLD_COUNTS=4 -> rst_out=1 two edges later, loss_count=1, rst_out stays high at least 4 cycles even if locked_in returns immediately.
4. force_rst and lock loss on the same cycle in S_RUN -> S_LOST, loss_count increments by exactly 1. force_rst alone -> S_LOST, loss_count unchanged.
5. LOSS_CNT_W=2; five lock-loss events -> loss_count saturates at 3. n_rst pulse mid-S_LOST -> S_WAIT, loss_count=0, rst_out=1.
6. LOCK_TIMEOUT_EN, TIMEOUT_COUNTS=50, locked_in held 0 -> lock_timeout=1 after 50 cycles, held. Lock then acquired -> lock_timeout clears on S_RUN entry.
